// File: rtl/rv_lsu_dmem.sv
// Sized load/store front end over an on-chip data RAM: valid/ready request and
// response channels, one request per cycle, one-cycle response latency.
module rv_lsu_dmem #(
  parameter int                     XLEN      = 64,
  parameter int                     DEPTH     = 1024,
  parameter int                     ADDR_WID  = 32,
  parameter logic [ADDR_WID-1:0]    BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_WID-1:0] req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_we
);

  localparam int NB    = XLEN / 8;
  localparam int OFS   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WID:0] RANGE = (ADDR_WID+1)'(DEPTH * NB);

  logic                accept;
  logic [ADDR_WID-1:0] off;
  logic [OFS-1:0]      lane;
  logic [IDX_W-1:0]    idx;
  logic                misaligned;
  logic                out_of_range;
  logic                bad_size;
  logic                err;
  logic [7:0]          be8;
  logic [NB-1:0]       be;
  logic [XLEN-1:0]     wdata_sh;

  logic [XLEN-1:0]     mem [DEPTH];
  logic [XLEN-1:0]     word_q;

  logic                rsp_valid_q, rsp_valid_d;
  logic                err_q;
  logic                we_q;
  logic                uns_q;
  logic [1:0]          size_q;
  logic [OFS-1:0]      lane_q;

  logic [XLEN-1:0]     sh;
  logic [XLEN-1:0]     mask;
  logic                sgn;
  logic [XLEN-1:0]     ext;

  // A response slot frees up in the same cycle it is consumed.
  assign req_ready = !rst && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  assign off  = req_addr - BASE_ADDR;
  assign lane = off[OFS-1:0];
  assign idx  = off[OFS +: IDX_W];

  always_comb begin
    misaligned = 1'b0;
    be8        = 8'h01;
    case (req_size)
      2'd0: begin misaligned = 1'b0;      be8 = 8'h01; end
      2'd1: begin misaligned = off[0];    be8 = 8'h03; end
      2'd2: begin misaligned = |off[1:0]; be8 = 8'h0F; end
      default: begin misaligned = |off[2:0]; be8 = 8'hFF; end
    endcase
  end

  // Addresses below BASE_ADDR wrap to huge offsets and land out of range.
  assign out_of_range = {1'b0, off} >= RANGE;
  assign bad_size     = (req_size == 2'd3) && (XLEN == 32);
  assign err          = misaligned || out_of_range || bad_size;

  assign be       = NB'(be8) << lane;
  assign wdata_sh = req_wdata << {lane, 3'b000};

  // RAM array and its output register; neither is reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
    if (accept) word_q <= mem[idx];
  end

  assign rsp_valid_d = accept || (rsp_valid_q && !rsp_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'd0;
      lane_q      <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (accept) begin
        err_q  <= err;
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        size_q <= req_size;
        lane_q <= lane;
      end
    end
  end

  // Response alignment: shift lane down, mask to access width, extend.
  always_comb begin
    sh   = word_q >> {lane_q, 3'b000};
    mask = '1;
    sgn  = sh[XLEN-1];
    case (size_q)
      2'd0: begin mask = XLEN'(8'hFF);         sgn = sh[7];  end
      2'd1: begin mask = XLEN'(16'hFFFF);      sgn = sh[15]; end
      2'd2: begin mask = XLEN'(32'hFFFF_FFFF); sgn = sh[31]; end
      default: begin mask = '1;                sgn = sh[XLEN-1]; end
    endcase
    ext = (sh & mask) | ({XLEN{sgn && !uns_q}} & ~mask);
  end

  assign rsp_valid = rsp_valid_q && !rst;
  assign rsp_err   = rsp_valid_q && err_q && !rst;
  assign rsp_we    = rsp_valid_q && we_q && !rst;
  assign rsp_rdata = (rsp_valid_q && !err_q && !we_q && !rst) ? ext : '0;

endmodule
